// File: rtl/sum_collector.sv
// sum_collector: assembles LSB-first partial-sum chunks into a full-width result with valid/ready output.
// Optional SUM_COLLECTOR_PARITY_EN adds a registered result_parity output equal to ^result.
module sum_collector #(
  parameter int CHUNK_W    = 32,
  parameter int NUM_CHUNKS = 12,
  parameter int RESULT_W   = 381
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHUNK_W-1:0]  sum_chunk,
  input  logic                enable_S,
  input  logic                done,
  output logic [RESULT_W-1:0] result,
  output logic                carry_out,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic [1:0]          err_flags
`ifdef SUM_COLLECTOR_PARITY_EN
  , output logic              result_parity
`endif
);
  localparam int ASM_W = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = $clog2(NUM_CHUNKS) + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_DONE, VALID} state_t;
  state_t             state_q;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic [IDX_W-1:0]   idx_q;
  logic               done_q, done_rise, wr, last, load;
  int                 base;
  always_comb begin
    done_rise = done & ~done_q;
    wr        = enable_S && (state_q == IDLE || state_q == COLLECT);
    base      = state_q == IDLE ? 0 : int'(idx_q) * CHUNK_W;
    last      = state_q == COLLECT && idx_q == IDX_W'(NUM_CHUNKS - 1);
    load      = done_rise && (state_q == COLLECT || state_q == WAIT_DONE);
    asm_d     = (state_q == IDLE && wr) ? '0 : asm_q;
    if (wr) asm_d[base +: CHUNK_W] = sum_chunk;
  end
`ifdef SUM_COLLECTOR_PARITY_EN
  logic par_q, par_d, chunk_par;
  // only bits landing below RESULT_W contribute, so parity tracks ^result
  always_comb begin
    chunk_par = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) if (base + i < RESULT_W) chunk_par ^= sum_chunk[i];
    par_d = !wr ? par_q : (state_q == IDLE ? chunk_par : par_q ^ chunk_par);
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      asm_q        <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      result       <= '0;
      carry_out    <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err_flags    <= '0;
`ifdef SUM_COLLECTOR_PARITY_EN
      par_q         <= 1'b0;
      result_parity <= 1'b0;
`endif
    end else begin
      done_q <= done;
      asm_q  <= asm_d;
`ifdef SUM_COLLECTOR_PARITY_EN
      par_q <= par_d;
`endif
      if (wr) idx_q <= state_q == IDLE ? IDX_W'(1) : idx_q + 1'b1;
      case (state_q)
        IDLE: if (enable_S) begin
          err_flags <= '0;
          state_q   <= COLLECT;
          busy      <= 1'b1;
        end
        COLLECT: begin
          if (done_rise && !(enable_S && last)) err_flags[1] <= 1'b1;
          if (!done_rise && enable_S && last) state_q <= WAIT_DONE;
        end
        WAIT_DONE: if (enable_S) err_flags[0] <= 1'b1;
        VALID: begin
          if (enable_S) err_flags[0] <= 1'b1;
          if (result_ready) begin
            result_valid <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // asm_d already holds a chunk captured on the same edge as done_rise
      if (load) begin
        state_q      <= VALID;
        busy         <= 1'b0;
        result_valid <= 1'b1;
        result       <= asm_d[RESULT_W-1:0];
        carry_out    <= asm_d[RESULT_W];
`ifdef SUM_COLLECTOR_PARITY_EN
        result_parity <= par_d;
`endif
      end
    end
  end
endmodule

// File: doc/sum_collector.md
Name: sum_collector

Overview:
- Downstream stage of the chunked 381-bit adder controller. Captures each CHUNK_W-bit partial sum on the controller's sum-store strobe, LSB chunk first, into a full-width result register.
- Exposes the finished sum plus its carry-out to the consumer through a valid/ready handshake.
- Flags protocol errors: extra strobes, and completion before all chunks have arrived.

Parameters:
- CHUNK_W, 32, width of one partial-sum chunk.
- NUM_CHUNKS, 12, chunks per operation. CHUNK_W*NUM_CHUNKS must exceed RESULT_W.
- RESULT_W, 381, width of the final sum.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- sum_chunk  input  CHUNK_W  partial sum from the adder datapath
- enable_S  input  1  capture strobe, one cycle per chunk
- done  input  1  controller completion level; it may stay high for many cycles
- result  output  RESULT_W  assembled sum, registered
- carry_out  output  1  bit RESULT_W of the assembled vector, registered
- result_valid  output  1  result and carry_out are stable and valid
- result_ready  input  1  consumer accepts the result
- busy  output  1  high in COLLECT and WAIT_DONE
- err_flags  output  2  sticky error flags; bit0 = extra strobe, bit1 = short operation

Behaviour:
- Reset: all of the following clear to 0 and the state goes to IDLE: result, carry_out, result_valid, busy, err_flags, chunk index idx, internal assembly register asm (CHUNK_W*NUM_CHUNKS bits), done_q.
- Done edge: done_q registers done each cycle. done_rise = done & ~done_q. Only done_rise is acted on.
- IDLE:
  - enable_S=1: asm clears to {sum_chunk in bits [CHUNK_W-1:0], zeros elsewhere}; idx<=1; err_flags<=0; go to COLLECT.
  - done_rise alone in IDLE is ignored.
- COLLECT:
  - enable_S=1: asm[idx*CHUNK_W +: CHUNK_W] <= sum_chunk; idx<=idx+1.
  - If that capture is chunk NUM_CHUNKS-1, go to WAIT_DONE.
  - done_rise before all chunks are captured: set err_flags[1]; missing chunks stay zero; go to VALID.
  - done_rise together with the final enable_S: the chunk is captured first, then go straight to VALID with no error.
- WAIT_DONE:
  - enable_S: strobe is dropped and err_flags[0] is set.
  - done_rise: go to VALID.
- Entering VALID (registered, one cycle after the deciding edge):
  - result <= asm[RESULT_W-1:0]
  - carry_out <= asm[RESULT_W]
  - result_valid <= 1
  - Bits above RESULT_W are discarded.
- VALID:
  - result, carry_out and result_valid hold until result_ready=1.
  - On the handshake cycle: result_valid<=0 and go to IDLE. result keeps its last value.
  - enable_S in VALID, including the handshake cycle, is dropped and sets err_flags[0]. No new operation starts until IDLE.
- Latency: result_valid rises exactly 1 cycle after the done_rise cycle, or after the final capture cycle if done rose together with it.
- busy: high in COLLECT and WAIT_DONE only.
- idx: width is clog2(NUM_CHUNKS)+1 and it never wraps. A capture beyond NUM_CHUNKS-1 is impossible by construction.
- Reset mid-operation: aborts immediately; all state returns to reset values on the next edge, with no partial output.

Optional Feature:
- Macro: SUM_COLLECTOR_PARITY_EN.
- Defined:
  - Adds output port result_parity (1 bit), reset 0.
  - Parity is accumulated incrementally: XOR-reduction of each captured chunk's bits at or below RESULT_W-1, seeded on the IDLE capture.
  - Registered alongside result on entry to VALID, so it equals ^result.
  - Holds with result.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Nominal:
  - Stimulus: 12 strobes with chunk k = 32'h1000_0000+k, then done high 3 cycles later, result_ready=1.
  - Required: result_valid one cycle after done_rise; result[31:0]=32'h1000_0000; result[380:352]=29 LSBs of 32'h1000_000B; carry_out=0; err_flags=0; back to IDLE next cycle.
- Carry bit:
  - Stimulus: final chunk 32'hFFFF_FFFF, all others 0.
  - Required: carry_out=1 (bit 381); result[380:352]=29'h1FFF_FFFF.
- Short operation:
  - Stimulus: 5 strobes, then done_rise.
  - Required: err_flags=2'b10; chunks 5..11 read as zero; result_valid asserted.
- Backpressure plus extra strobe:
  - Stimulus: hold result_ready=0 for 10 cycles while pulsing enable_S twice.
  - Required: result stable; result_valid high; err_flags[0]=1; handshake completes when ready=1.
- Done held high:
  - Stimulus: done stays high across two back-to-back operations.
  - Required: the second operation waits in WAIT_DONE until done falls and rises again; no spurious result_valid.
- Reset mid-collect:
  - Stimulus: reset for 1 cycle after chunk 6.
  - Required: all outputs 0, state IDLE; the next 12-strobe operation produces the correct result with err_flags=0.
